// File: rtl/lcd_sync_module.sv
// Parameterised LCD panel timing generator: h/v counters, syncs, active window, pixel addresses.
// Syncs/ready/addresses are combinational from registered counters; lcd_de lags ready_sig by 1 clk.
module lcd_sync_module #(
    parameter int   H_SYNC   = 48,
    parameter int   H_BACK   = 88,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FRONT  = 40,
    parameter int   V_SYNC   = 3,
    parameter int   V_BACK   = 32,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 13,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        ready_sig,
    output logic [10:0] column_addr_sig,
    output logic [10:0] row_addr_sig,
    output logic        lcd_de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_MAX      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_ACT_BEG  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_END  = 11'(V_SYNC + V_BACK + V_ACTIVE);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        live_q;
    logic        lcd_de_q;
    logic        active;
    logic        h_wrap;
    logic        h_in;
    logic        v_in;

    // live_q keeps outputs idle between reset release and the first clk edge,
    // so the first visible cycle after reset is h_cnt = 0, v_cnt = 0.
    assign active = en & live_q;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        h_wrap  = (h_cnt_q == H_MAX);
        if (!active) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
            if (h_wrap) begin
                v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 11'd1;
            end
        end
    end

    always_comb begin
        lcd_hsync       = ~SYNC_POL;
        lcd_vsync       = ~SYNC_POL;
        ready_sig       = 1'b0;
        column_addr_sig = '0;
        row_addr_sig    = '0;
        frame_start     = 1'b0;
        h_in            = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
        v_in            = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
        if (active) begin
            if (h_cnt_q < H_SYNC_END) begin
                lcd_hsync = SYNC_POL;
            end
            if (v_cnt_q < V_SYNC_END) begin
                lcd_vsync = SYNC_POL;
            end
            ready_sig   = h_in & v_in;
            frame_start = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
            if (h_in && v_in) begin
                column_addr_sig = h_cnt_q - H_ACT_BEG;
                row_addr_sig    = v_cnt_q - V_ACT_BEG;
            end
        end
    end

    // Gating with active stops a stale registered enable leaking out when en drops.
    assign lcd_de = lcd_de_q & active;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            live_q   <= 1'b0;
            lcd_de_q <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            live_q   <= 1'b1;
            lcd_de_q <= ready_sig;
        end
    end

endmodule

// File: tb/tb_lcd_sync_module.sv
// Scoreboarded bench for lcd_sync_module: the model tracks position within the frame as one
// linear pixel index and derives row/column/sync expectations arithmetically from it.
module tb_lcd_sync_module;

    localparam int   HS = 4,  HB = 3, HA = 10, HF = 2;
    localparam int   VS = 2,  VB = 2, VA = 5,  VF = 1;
    localparam logic POL = 1'b0;
    localparam int   HT = HS + HB + HA + HF;
    localparam int   VT = VS + VB + VA + VF;
    localparam int   FRAME = HT * VT;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        en   = 1'b0;
    logic        lcd_hsync, lcd_vsync, ready_sig, lcd_de, frame_start;
    logic [10:0] column_addr_sig, row_addr_sig;

    lcd_sync_module #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(POL)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .en              (en),
        .lcd_hsync       (lcd_hsync),
        .lcd_vsync       (lcd_vsync),
        .ready_sig       (ready_sig),
        .column_addr_sig (column_addr_sig),
        .row_addr_sig    (row_addr_sig),
        .lcd_de          (lcd_de),
        .frame_start     (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        rdy;
        logic        de;
        logic        fs;
        logic [10:0] col;
        logic [10:0] row;
    } obs_t;

    obs_t exp_q[$];
    obs_t last = '0;
    int   checks = 0;
    int   errors = 0;

    // Reference state: live = a clk edge has passed since reset, t = pixel index in frame,
    // de = ready of the previous cycle.
    bit m_live = 1'b0;
    int m_t    = 0;
    bit m_de   = 1'b0;

    bit count_win = 1'b0;
    int cnt_fs = 0, cnt_de = 0, cnt_hs = 0, cnt_vs = 0;

    function automatic obs_t model_out();
        obs_t o;
        int   h, v;
        bit   act;
        o   = '0;
        act = m_live && en && rstn;
        h   = m_t % HT;
        v   = m_t / HT;
        o.hs  = (act && h < HS) ? POL : ~POL;
        o.vs  = (act && v < VS) ? POL : ~POL;
        o.rdy = act && (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        o.col = o.rdy ? 11'(h - (HS + HB)) : 11'd0;
        o.row = o.rdy ? 11'(v - (VS + VB)) : 11'd0;
        o.de  = act && m_de;
        o.fs  = act && (m_t == 0);
        return o;
    endfunction

    task automatic model_reset();
        m_live = 1'b0;
        m_t    = 0;
        m_de   = 1'b0;
    endtask

    task automatic model_edge();
        if (!rstn) begin
            model_reset();
        end else begin
            m_de   = last.rdy;
            m_t    = (m_live && en) ? (m_t + 1) % FRAME : 0;
            m_live = 1'b1;
        end
    endtask

    // One clock cycle: advance model at the edge, drive new inputs, queue expectation,
    // optionally release reset between the negedge sample and the next edge.
    task automatic step(input bit en_v, input bit rstn_v, input bit release_mid);
        @(posedge clk);
        model_edge();
        #1;
        en   = en_v;
        rstn = rstn_v;
        if (!rstn) model_reset();
        last = model_out();
        exp_q.push_back(last);
        @(negedge clk);
        #1;
        if (release_mid) rstn = 1'b1;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{lcd_hsync, lcd_vsync, ready_sig, lcd_de, frame_start,
                      column_addr_sig, row_addr_sig};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got hs=%b vs=%b rdy=%b de=%b fs=%b col=%0d row=%0d, expected hs=%b vs=%b rdy=%b de=%b fs=%b col=%0d row=%0d",
                             $time, a.hs, a.vs, a.rdy, a.de, a.fs, a.col, a.row,
                             e.hs, e.vs, e.rdy, e.de, e.fs, e.col, e.row);
                end
                if (count_win) begin
                    cnt_fs += int'(frame_start);
                    cnt_de += int'(lcd_de);
                    cnt_hs += int'(lcd_hsync == POL);
                    cnt_vs += int'(lcd_vsync == POL);
                end
            end
        end
    end

    initial begin : stimulus
        int en_low;
        bit found;

        // Reset held with en high, then release: one idle cycle before the frame starts.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Two full frames from the first enabled cycle; totals follow from the timing parameters.
        count_win = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b1, 1'b0);
        count_win = 1'b0;
        check_count("frame_start_pulses", cnt_fs, 2);
        check_count("lcd_de_cycles", cnt_de, 2 * HA * VA);
        check_count("hsync_active_cycles", cnt_hs, 2 * VT * HS);
        check_count("vsync_active_cycles", cnt_vs, 2 * VS * HT);

        // Drop en for 10 clk in the middle of an active line, then re-enable.
        found = 1'b0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            step(1'b1, 1'b1, 1'b0);
            found = last.rdy && (last.row == 11'd2) && (last.col == 11'd4);
        end
        check_count("reach_mid_line_for_en_drop", int'(found), 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < FRAME + 5; i++) step(1'b1, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges in the middle of an active line.
        found = 1'b0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            step(1'b1, 1'b1, 1'b0);
            found = last.rdy && (last.col == 11'd5);
        end
        check_count("reach_mid_line_for_reset", int'(found), 1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < FRAME + 5; i++) step(1'b1, 1'b1, 1'b0);

        // Random en gaps and occasional reset pulses.
        en_low = 0;
        for (int i = 0; i < 3000; i++) begin
            bit e_v, r_v, rel;
            if (en_low > 0) en_low--;
            else if ($urandom_range(0, 149) == 0) en_low = $urandom_range(1, 12);
            e_v = (en_low == 0);
            r_v = 1'b1;
            rel = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                r_v = 1'b0;
                rel = 1'($urandom_range(0, 1));
            end
            step(e_v, r_v, rel);
        end

        @(negedge clk);
        #1;
        check_count("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
